// File: rtl/imem_boot_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_loader_pkg
// Brief    : State encoding and shared constants for the instruction loader.
// Revision : 1.0
// ============================================================================
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

  localparam int          c_word_bytes        = 4;
  localparam int          c_default_depth     = 64;
  localparam logic [31:0] c_default_base_addr = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_loader
// Brief    : Streams instruction words into imem and holds the core until done.
// Revision : 1.0
// ============================================================================
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int          DEPTH     = c_default_depth,
  parameter logic [31:0] BASE_ADDR = c_default_base_addr,
  parameter int          CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_start,
  input  logic [CNT_W-1:0] load_len,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             imem_we,
  output logic [31:0]      imem_ads,
  output logic [31:0]      imem_din,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [31:0]      checksum
);

  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

  state_e           r_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_remaining;
  logic [31:0]      r_checksum;
  logic [31:0]      r_ads;
  logic [31:0]      r_din;
  logic             r_we;
  logic             r_done;
  logic             r_error;

  logic             w_len_ok;
  logic             w_can_start;
  logic             w_xfer;
  logic             w_last;
  logic [31:0]      w_word_ads;

  assign w_len_ok    = (load_len != '0) && (load_len <= c_depth);
  assign w_can_start = (r_state == ST_IDLE) || (r_state == ST_RUN) || (r_state == ST_ERROR);
  assign w_xfer      = in_valid && (r_state == ST_LOAD);
  assign w_last      = (r_count == (r_remaining - c_one));
  // Wraps modulo 2^32; the length check keeps it inside the memory window.
  assign w_word_ads  = BASE_ADDR + (32'(r_count) * 32'(c_word_bytes));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_remaining <= '0;
      r_checksum  <= '0;
      r_ads       <= '0;
      r_din       <= '0;
      r_we        <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_RUN, ST_ERROR: begin
          if (load_start && w_can_start) begin
            if (w_len_ok) begin
              r_state     <= ST_LOAD;
              r_count     <= '0;
              r_remaining <= load_len;
              r_checksum  <= '0;
              r_error     <= 1'b0;
            end else begin
              r_state <= ST_ERROR;
              r_error <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          // load_start is deliberately ignored while a load is in flight.
          if (w_xfer) begin
            r_we       <= 1'b1;
            r_ads      <= w_word_ads;
            r_din      <= in_data;
            r_count    <= r_count + c_one;
            r_checksum <= r_checksum ^ in_data;
            if (w_last) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          r_state <= ST_RUN;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready = (r_state == ST_LOAD);
  assign cpu_hold = (r_state != ST_RUN);
  assign busy     = (r_state == ST_LOAD) || (r_state == ST_DRAIN);
  assign imem_we  = r_we;
  assign imem_ads = r_ads;
  assign imem_din = r_din;
  assign done     = r_done;
  assign error    = r_error;
  assign checksum = r_checksum;

endmodule

`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_boot_loader
// Brief    : Directed self-checking bench for imem_boot_loader.
// Revision : 1.0
// ============================================================================
module tb_imem_boot_loader;

  localparam int CNT_W = 7;

  logic             clk;
  logic             reset;
  logic             load_start;
  logic [CNT_W-1:0] load_len;
  logic             in_valid;
  logic [31:0]      in_data;

  logic             in_ready, imem_we, cpu_hold, busy, done, error;
  logic [31:0]      imem_ads, imem_din, checksum;

  logic             b_in_ready, b_imem_we, b_cpu_hold, b_busy, b_done, b_error;
  logic [31:0]      b_imem_ads, b_imem_din, b_checksum;

  int checks;
  int errors;

  imem_boot_loader #(.DEPTH(64), .BASE_ADDR(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_len(load_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_ads(imem_ads), .imem_din(imem_din),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
    .checksum(checksum)
  );

  // Second instance shares the stimulus but writes from a non-zero base.
  imem_boot_loader #(.DEPTH(64), .BASE_ADDR(32'h0000_0100), .CNT_W(CNT_W)) dut_b (
    .clk(clk), .reset(reset), .load_start(load_start), .load_len(load_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(b_in_ready),
    .imem_we(b_imem_we), .imem_ads(b_imem_ads), .imem_din(b_imem_din),
    .cpu_hold(b_cpu_hold), .busy(b_busy), .done(b_done), .error(b_error),
    .checksum(b_checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_imem_we",  32'(imem_we),  32'd0);
    chk("rst_error",    32'(error),    32'd0);
    chk("rst_checksum", checksum,      32'h0);
    reset = 1'b1;
    step();
    chk("idle_busy",     32'(busy),     32'd0);
    chk("idle_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("idle_in_ready", 32'(in_ready), 32'd0);
  endtask

  task automatic test_load3();
    logic [31:0] words [3];
    words[0] = 32'h0000_0033;
    words[1] = 32'h4000_0033;
    words[2] = 32'h0050_0093;
    load_start = 1'b1; load_len = 7'd3;
    step();
    load_start = 1'b0;
    chk("l3_in_ready", 32'(in_ready), 32'd1);
    chk("l3_busy",     32'(busy),     32'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = words[i];
      step();
      chk("l3_we",  32'(imem_we), 32'd1);
      chk("l3_ads", imem_ads,     32'(i * 4));
      chk("l3_din", imem_din,     words[i]);
    end
    in_valid = 1'b0;
    chk("l3_drain_ready", 32'(in_ready), 32'd0);
    chk("l3_drain_busy",  32'(busy),     32'd1);
    chk("l3_drain_done",  32'(done),     32'd0);
    step();
    chk("l3_done",     32'(done),     32'd1);
    chk("l3_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("l3_we_off",   32'(imem_we),  32'd0);
    chk("l3_checksum", checksum,      32'h4050_0093);
    step();
    chk("l3_done_pulse", 32'(done),     32'd0);
    chk("l3_run_hold",   32'(cpu_hold), 32'd0);
  endtask

  task automatic test_backpressure();
    int writes;
    writes = 0;
    load_start = 1'b1; load_len = 7'd2;
    step();
    load_start = 1'b0;
    chk("bp_cpu_hold", 32'(cpu_hold), 32'd1);
    in_valid = 1'b1; in_data = 32'h1111_1111;
    step();
    in_valid = 1'b0;
    if (imem_we) writes++;
    chk("bp_ads0", imem_ads, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      if (imem_we) writes++;
      chk("bp_gap_we",    32'(imem_we),  32'd0);
      chk("bp_gap_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b1; in_data = 32'h2222_2222;
    step();
    in_valid = 1'b0;
    if (imem_we) writes++;
    chk("bp_ads1", imem_ads, 32'h4);
    chk("bp_din1", imem_din, 32'h2222_2222);
    step();
    if (imem_we) writes++;
    chk("bp_writes",   32'(writes),   32'd2);
    chk("bp_done",     32'(done),     32'd1);
    chk("bp_checksum", checksum,      32'h3333_3333);
  endtask

  task automatic test_len_errors();
    load_start = 1'b1; load_len = 7'd0;
    step();
    load_start = 1'b0;
    chk("e0_error",    32'(error),    32'd1);
    chk("e0_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("e0_in_ready", 32'(in_ready), 32'd0);
    chk("e0_checksum", checksum,      32'h3333_3333);
    step();
    chk("e0_sticky", 32'(error), 32'd1);
    load_start = 1'b1; load_len = 7'd65;
    step();
    load_start = 1'b0;
    chk("e65_error",    32'(error),    32'd1);
    chk("e65_in_ready", 32'(in_ready), 32'd0);
    chk("e65_busy",     32'(busy),     32'd0);
    load_start = 1'b1; load_len = 7'd1;
    step();
    load_start = 1'b0;
    chk("e1_error",    32'(error),    32'd0);
    chk("e1_in_ready", 32'(in_ready), 32'd1);
    chk("e1_checksum", checksum,      32'h0);
    in_valid = 1'b1; in_data = 32'h0000_000A;
    step();
    in_valid = 1'b0;
    chk("e1_we", 32'(imem_we), 32'd1);
    step();
    chk("e1_done", 32'(done), 32'd1);
  endtask

  task automatic test_reset_midload();
    load_start = 1'b1; load_len = 7'd4;
    step();
    load_start = 1'b0;
    in_valid = 1'b1; in_data = 32'h0000_0001;
    step();
    in_data = 32'h0000_0002;
    step();
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rml_we",       32'(imem_we),  32'd0);
    chk("rml_checksum", checksum,      32'h0);
    chk("rml_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rml_busy",     32'(busy),     32'd0);
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_ignored_start();
    load_start = 1'b1; load_len = 7'd3;
    step();
    load_start = 1'b0;
    in_valid = 1'b1; in_data = 32'h0000_0010;
    step();
    load_start = 1'b1; load_len = 7'd5; in_data = 32'h0000_0020;
    step();
    load_start = 1'b0;
    chk("ign_ads1", imem_ads, 32'h4);
    in_data = 32'h0000_0040;
    step();
    in_valid = 1'b0;
    chk("ign_ads2",     imem_ads,      32'h8);
    chk("ign_drain",    32'(in_ready), 32'd0);
    chk("ign_checksum", checksum,      32'h0000_0070);
    step();
    chk("ign_done", 32'(done),     32'd1);
    chk("ign_run",  32'(cpu_hold), 32'd0);
  endtask

  task automatic test_reload_base();
    step();
    chk("rl_b_run", 32'(b_cpu_hold), 32'd0);
    load_start = 1'b1; load_len = 7'd1;
    step();
    load_start = 1'b0;
    chk("rl_b_hold",  32'(b_cpu_hold), 32'd1);
    chk("rl_a_hold",  32'(cpu_hold),   32'd1);
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    step();
    in_valid = 1'b0;
    chk("rl_b_we",  32'(b_imem_we), 32'd1);
    chk("rl_b_ads", b_imem_ads,     32'h0000_0100);
    chk("rl_b_din", b_imem_din,     32'hDEAD_BEEF);
    chk("rl_a_ads", imem_ads,       32'h0);
    step();
    chk("rl_b_done", 32'(b_done), 32'd1);
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0; load_start = 1'b0; load_len = '0;
    in_valid = 1'b0; in_data = '0;
    test_reset();
    test_load3();
    test_backpressure();
    test_len_errors();
    test_reset_midload();
    test_ignored_start();
    test_reload_base();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream of instruction fetch; fills instruction memory (memoria_ins write port) from a word stream before the multicycle core runs.
- Takes 32-bit instruction words over a valid/ready handshake and writes them to consecutive word addresses starting at BASE_ADDR.
- Holds the core via cpu_hold until loading finishes. cpu_hold drives the fetch-address select and the UC state-machine hold.
- Replaces the bench-driven instruction path into fetch.

Parameters:
- DEPTH, 64: instruction memory capacity in 32-bit words.
- BASE_ADDR, 0: byte address of the first loaded word.
- CNT_W, clog2(DEPTH)+1: width of load_len and the word counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- load_start  in  1  one-cycle request to begin a load.
- load_len  in  CNT_W  number of words to load; sampled with load_start.
- in_valid  in  1  in_data holds a word.
- in_data  in  32  instruction word.
- in_ready  out  1  loader accepts a word this cycle.
- imem_we  out  1  instruction memory write enable.
- imem_ads  out  32  instruction memory byte address.
- imem_din  out  32  instruction memory write data.
- cpu_hold  out  1  1 = core held, fetch from loader; 0 = core runs from PC.
- busy  out  1  high in LOAD or DRAIN.
- done  out  1  one-cycle pulse on entry to RUN.
- error  out  1  sticky while in ERROR.
- checksum  out  32  XOR of all words accepted in the current load.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - in_ready=0, imem_we=0, imem_ads=0, imem_din=0, busy=0, done=0, error=0, checksum=0.
  - cpu_hold=1.
- States: IDLE, LOAD, DRAIN, RUN, ERROR.
- Outputs per state:
  - cpu_hold=1 in IDLE, LOAD, DRAIN and ERROR; 0 only in RUN.
  - in_ready=1 only in LOAD.
- Accepting load_start (in IDLE, RUN or ERROR):
  - If load_len==0 or load_len>DEPTH: go to ERROR, error=1.
  - Otherwise: go to LOAD, count=0, remaining=load_len, checksum=0, error=0.
  - cpu_hold rises the cycle after load_start when leaving RUN.
- load_start in LOAD or DRAIN is ignored. No effect on count, len or checksum.
- Word transfer in LOAD: occurs when in_valid & in_ready are high at a rising edge.
  - Next cycle: imem_we=1, imem_ads=BASE_ADDR+4*count, imem_din=that word.
  - Write latency is exactly 1 cycle.
  - Then count increments and checksum ^= word.
  - imem_we=0 in any cycle following no transfer.
- Last word (count==remaining-1 on transfer):
  - Go to DRAIN; in_ready=0 in DRAIN.
  - DRAIN lasts exactly one cycle and carries the last imem_we.
  - DRAIN -> RUN; done=1 for the first RUN cycle only.
- in_valid deasserted mid-load: stay in LOAD indefinitely; no timeout.
- Address arithmetic is 32-bit modulo 2^32. Address never exceeds BASE_ADDR+4*(DEPTH-1), guaranteed by the length check.
- checksum holds its final value in RUN and ERROR until the next accepted load_start.
- Reset mid-load: immediate return to IDLE. A partially written memory is not cleaned. cpu_hold stays 1.
- RUN persists until the next load_start or reset.
- error clears only on an accepted valid load_start or on reset.

Decomposition:
- Shared package holds:
  - State encoding: IDLE=0, LOAD=1, DRAIN=2, RUN=3, ERROR=4, 3 bits.
  - Word size constant 4.
  - Defaults for DEPTH and BASE_ADDR.
- Single flat module; FSM and write-register stage are too small to justify a sub-module.

Test Plan:
- Reset then idle:
  - Stimulus: reset=0 for 2 cycles, then release.
  - Required: cpu_hold=1, in_ready=0, imem_we=0, error=0, state IDLE.
- Load 3 words, valid held high:
  - Stimulus: load_len=3, words 0x00000033, 0x40000033, 0x00500093.
  - Required: imem_we high 3 consecutive cycles at ads 0x0, 0x4, 0x8 with matching din.
  - Required: DRAIN carries the 0x8 write; done pulses 1 cycle; cpu_hold=0 the next cycle; checksum=0x40500093.
- Backpressure gaps:
  - Stimulus: load_len=2 with in_valid low for 3 cycles between the two words.
  - Required: exactly 2 writes, at 0x0 and 0x4; no spurious imem_we during the gap.
- Length errors:
  - Stimulus: load_len=0; separately load_len=DEPTH+1=65.
  - Required: ERROR, error=1, cpu_hold=1, in_ready=0.
  - Follow-up: load_len=1 -> LOAD, error=0.
- Reset mid-load and ignored start:
  - Stimulus: assert reset after 2 of 4 words accepted.
  - Required: IDLE immediately, imem_we=0, checksum=0.
  - Stimulus: load_start pulsed during LOAD with load_len=5.
  - Required: original length still completes.
- Reload from RUN with BASE_ADDR=0x100:
  - Stimulus: load_start in RUN.
  - Required: cpu_hold returns to 1; first write lands at 0x100.
